fifo_uart_tx: RTL and testbench

//   Downstream drain stage for the 8-bit synchronous FIFO: pops one byte when the FIFO is non-empty,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL   = 1'b0;
   localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done_o on the last cycle of each bit.
// Held at zero while clear_i is high so every frame starts on a fresh bit boundary.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic bit_done_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      bit_done_o = !clear_i && (count_q == LAST_COUNT);
      count_d    = (clear_i || bit_done_o) ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO one byte at a time and sends each byte as a UART frame on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              fifo_empty_i,
   input  logic [DATA_W-1:0] fifo_data_i,
   output logic              fifo_rd_en_o,
   output logic              tx_o,
   output logic              busy_o
);

   localparam int IDX_W = $clog2(DATA_W + 1);

   tx_state_t         state_q;
   logic [DATA_W-1:0] shiftReg_q;
   logic [IDX_W-1:0]  bitIdx_q;
   logic              tx_q;
   logic              bitDone;
   logic              baudClear;
`ifdef UART_TX_PARITY_EN
   logic              parity_q;
`endif

   // WAIT is the FIFO read-latency slot, so the baud counter must not run before START.
   assign baudClear    = (state_q == IDLE) || (state_q == WAIT);
   assign fifo_rd_en_o = !rst && (state_q == IDLE) && enable_i && !fifo_empty_i;
   assign tx_o         = tx_q;
   assign busy_o       = (state_q != IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (baudClear),
      .bit_done_o(bitDone)
   );

   // tx_q is loaded with the level of the state being entered, keeping the pin purely registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         bitIdx_q   <= '0;
         tx_q       <= TX_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= TX_IDLE_LEVEL;
               if (fifo_rd_en_o) state_q <= WAIT;
            end
            WAIT: begin
               shiftReg_q <= fifo_data_i;
`ifdef UART_TX_PARITY_EN
               parity_q   <= ^fifo_data_i;
`endif
               bitIdx_q   <= '0;
               tx_q       <= START_LEVEL;
               state_q    <= START;
            end
            START: begin
               if (bitDone) begin
                  tx_q    <= shiftReg_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (bitDone) begin
                  shiftReg_q <= shiftReg_q >> 1;
                  if (bitIdx_q == IDX_W'(DATA_W - 1)) begin
                     bitIdx_q <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_q     <= parity_q;
                     state_q  <= PARITY;
`else
                     tx_q     <= STOP_LEVEL;
                     state_q  <= STOP;
`endif
                  end else begin
                     bitIdx_q <= bitIdx_q + 1'b1;
                     tx_q     <= shiftReg_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bitDone) begin
                  bitIdx_q <= '0;
                  tx_q     <= STOP_LEVEL;
                  state_q  <= STOP;
               end
            end
`endif
            STOP: begin
               if (bitDone) begin
                  if (bitIdx_q == IDX_W'(STOP_BITS - 1)) begin
                     bitIdx_q <= '0;
                     tx_q     <= TX_IDLE_LEVEL;
                     state_q  <= IDLE;
                  end else begin
                     bitIdx_q <= bitIdx_q + 1'b1;
                  end
               end
            end
            default: begin
               tx_q    <= TX_IDLE_LEVEL;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised self-checking bench for fifo_uart_tx against a frame-level reference model.
// The reference model expands each popped byte into its expected per-cycle line levels.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
   localparam int DW  = 8;
   localparam int SB  = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          fifoEmpty;
   logic [DW-1:0] fifoData;
   logic          rdEn;
   logic          tx;
   logic          busy;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (DW),
      .STOP_BITS   (SB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable_i    (enable),
      .fifo_empty_i(fifoEmpty),
      .fifo_data_i (fifoData),
      .fifo_rd_en_o(rdEn),
      .tx_o        (tx),
      .busy_o      (busy)
   );

   logic [DW-1:0] fifoQ[$];
   logic          txQ[$];
   logic          lastRd = 1'b0;
   int            errors = 0;
   int            checks = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Expected line level for every cycle from the WAIT slot to the end of the stop bits.
   task automatic buildFrame(input logic [DW-1:0] b);
      txQ.push_back(1'b1);
      repeat (CPB) txQ.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (CPB) txQ.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      repeat (CPB) txQ.push_back(^b);
`endif
      repeat (SB * CPB) txQ.push_back(1'b1);
   endtask

   task automatic applyStimulus(input logic en, input logic r);
      logic expRd;
      @(negedge clk);
      if (lastRd && fifoQ.size() != 0) fifoData = fifoQ.pop_front();
      enable    = en;
      rst       = r;
      fifoEmpty = (fifoQ.size() == 0);
      #1;
      checkOutput("tx", {31'd0, tx}, {31'd0, (txQ.size() != 0) ? txQ[0] : 1'b1});
      checkOutput("busy", {31'd0, busy}, {31'd0, txQ.size() != 0});
      expRd = !r && (txQ.size() == 0) && en && !fifoEmpty;
      if (!r) checkOutput("rd_en", {31'd0, rdEn}, {31'd0, expRd});
      lastRd = rdEn;
      if (r)                   txQ.delete();
      else if (txQ.size() != 0) void'(txQ.pop_front());
      else if (expRd)          buildFrame(fifoQ[0]);
   endtask

   task automatic runCycles(input int n, input logic en, input logic r);
      for (int i = 0; i < n; i++) applyStimulus(en, r);
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      fifoEmpty = 1'b1;
      fifoData  = '0;

      $display("[TB] reset and empty FIFO");
      runCycles(3, 1'b1, 1'b1);
      runCycles(100, 1'b1, 1'b0);

      $display("[TB] single byte 0xA5");
      fifoQ.push_back(8'hA5);
      runCycles(60, 1'b1, 1'b0);

      $display("[TB] back-to-back 0x00 0xFF 0x3C");
      fifoQ.push_back(8'h00);
      fifoQ.push_back(8'hFF);
      fifoQ.push_back(8'h3C);
      runCycles(150, 1'b1, 1'b0);

      $display("[TB] enable dropped mid-frame");
      fifoQ.push_back(8'h81);
      fifoQ.push_back(8'h42);
      runCycles(20, 1'b1, 1'b0);
      runCycles(70, 1'b0, 1'b0);
      runCycles(60, 1'b1, 1'b0);

      $display("[TB] reset during data bit 5");
      fifoQ.push_back(8'h5A);
      runCycles(28, 1'b1, 1'b0);
      runCycles(1, 1'b1, 1'b1);
      runCycles(40, 1'b1, 1'b0);

      $display("[TB] randomised traffic");
      enable = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic en;
         logic r;
         en = enable;
         if ($urandom_range(49) == 0) en = ~en;
         r = ($urandom_range(399) == 0);
         if ($urandom_range(7) == 0 && fifoQ.size() < 8) fifoQ.push_back(8'($urandom));
         applyStimulus(en, r);
      end

      runCycles(600, 1'b1, 1'b0);
      checkOutput("fifo_drained", fifoQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
